// File: rtl/pdma_wconv_fifo.sv
// Width-down-converting synchronous FIFO: wide words in, RWIDTH sub-words out,
// with almost-full/almost-empty flags, over/underflow pulses and synchronous flush.
module pdma_wconv_fifo #(
  parameter  int unsigned RWIDTH    = 8,
  parameter  int unsigned RATIO     = 2,
  parameter  int unsigned WDEPTH    = 100,
  parameter  int unsigned AFVAL     = 99,
  parameter  int unsigned AEVAL     = 4,
  parameter  bit          LSB_FIRST = 1'b1,
  localparam int unsigned WWIDTH    = RATIO * RWIDTH,
  localparam int unsigned WCW       = $clog2(WDEPTH + 1),
  localparam int unsigned RCW       = $clog2(WDEPTH * RATIO + 1)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WE,
  input  logic [WWIDTH-1:0] DATA,
  input  logic              RE,
  input  logic              FLUSH,
  output logic [RWIDTH-1:0] Q,
  output logic              DVLD,
  output logic              WACK,
  output logic              FULL,
  output logic              EMPTY,
  output logic              AFULL,
  output logic              AEMPTY,
  output logic              OVERFLOW,
  output logic              UNDERFLOW,
  output logic [WCW-1:0]    WRCNT,
  output logic [RCW-1:0]    RDCNT
);

  localparam int unsigned PW = $clog2(WDEPTH);
  localparam int unsigned SW = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [WWIDTH-1:0] mem_q [WDEPTH];

  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [SW-1:0]     sidx_q, sidx_d;
  logic [WCW-1:0]    wcnt_q, wcnt_d;
  logic [RCW-1:0]    rcnt_q, rcnt_d;
  logic [RWIDTH-1:0] q_q, q_d;
  logic              dvld_q, dvld_d, wack_q, wack_d, ovf_q, ovf_d, udf_q, udf_d;
  logic              full_q, full_d, empty_q, empty_d, afull_q, afull_d, aempty_q, aempty_d;

  logic              wr_acc, rd_acc, last_sub;
  logic [SW-1:0]     sel;
  logic [WWIDTH-1:0] rword;
  logic [RWIDTH-1:0] rsub;

  // Acceptance looks only at registered flags; flush blocks both sides.
  assign wr_acc   = WE & ~full_q & ~FLUSH;
  assign rd_acc   = RE & ~empty_q & ~FLUSH;
  assign last_sub = (sidx_q == SW'(RATIO - 1));

  // Sub-word selection in the configured order.
  always_comb begin
    rword = mem_q[rptr_q];
    sel   = LSB_FIRST ? sidx_q : (SW'(RATIO - 1) - sidx_q);
    rsub  = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (sel == SW'(i)) rsub = rword[i*RWIDTH +: RWIDTH];
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    sidx_d = sidx_q;
    wcnt_d = wcnt_q;
    rcnt_d = rcnt_q;
    q_d    = q_q;
    dvld_d = 1'b0;
    wack_d = 1'b0;
    ovf_d  = 1'b0;
    udf_d  = 1'b0;
    if (FLUSH) begin
      wptr_d = '0;
      rptr_d = '0;
      sidx_d = '0;
      wcnt_d = '0;
      rcnt_d = '0;
    end else begin
      wack_d = wr_acc;
      dvld_d = rd_acc;
      ovf_d  = WE & full_q;
      udf_d  = RE & empty_q;
      if (wr_acc) wptr_d = (wptr_q == PW'(WDEPTH - 1)) ? '0 : wptr_q + PW'(1);
      if (rd_acc) begin
        q_d = rsub;
        if (last_sub) begin
          sidx_d = '0;
          rptr_d = (rptr_q == PW'(WDEPTH - 1)) ? '0 : rptr_q + PW'(1);
        end else begin
          sidx_d = sidx_q + SW'(1);
        end
      end
      // A slot is freed only once its last sub-word has been read.
      wcnt_d = wcnt_q + WCW'(wr_acc) - WCW'(rd_acc & last_sub);
      rcnt_d = rcnt_q + (wr_acc ? RCW'(RATIO) : RCW'(0)) - RCW'(rd_acc);
    end
    full_d   = (wcnt_d == WCW'(WDEPTH));
    empty_d  = (rcnt_d == '0);
    afull_d  = (wcnt_d >= WCW'(AFVAL));
    aempty_d = (rcnt_d <= RCW'(AEVAL));
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      sidx_q   <= '0;
      wcnt_q   <= '0;
      rcnt_q   <= '0;
      q_q      <= '0;
      dvld_q   <= 1'b0;
      wack_q   <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      sidx_q   <= sidx_d;
      wcnt_q   <= wcnt_d;
      rcnt_q   <= rcnt_d;
      q_q      <= q_d;
      dvld_q   <= dvld_d;
      wack_q   <= wack_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  // Storage has no reset; contents are meaningless until written.
  always_ff @(posedge CLK) begin
    if (wr_acc) mem_q[wptr_q] <= DATA;
  end

  assign Q         = q_q;
  assign DVLD      = dvld_q;
  assign WACK      = wack_q;
  assign FULL      = full_q;
  assign EMPTY     = empty_q;
  assign AFULL     = afull_q;
  assign AEMPTY    = aempty_q;
  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = udf_q;
  assign WRCNT     = wcnt_q;
  assign RDCNT     = rcnt_q;

endmodule

// File: tb/tb_pdma_wconv_fifo.sv
// Self-checking bench for pdma_wconv_fifo: byte-queue reference model, randomized streaming,
// plus an MSB-first instance sharing the same stimulus for sub-word order checks.
module tb_pdma_wconv_fifo;
  localparam int WDEPTH = 100;
  localparam int AFVAL  = 99;
  localparam int AEVAL  = 4;

  logic        CLK = 1'b0, RESET = 1'b0, WE = 1'b0, RE = 1'b0, FLUSH = 1'b0;
  logic [15:0] DATA = 16'h0;

  logic [7:0] Q, q1;
  logic       DVLD, WACK, FULL, EMPTY, AFULL, AEMPTY, OVERFLOW, UNDERFLOW;
  logic       dvld1, wack1, full1, empty1, afull1, aempty1, ovf1, udf1;
  logic [6:0] WRCNT, wrcnt1;
  logic [7:0] RDCNT, rdcnt1;

  int tests = 0;
  int fails = 0;

  pdma_wconv_fifo #(.LSB_FIRST(1'b1)) u0 (
    .CLK(CLK), .RESET(RESET), .WE(WE), .DATA(DATA), .RE(RE), .FLUSH(FLUSH),
    .Q(Q), .DVLD(DVLD), .WACK(WACK), .FULL(FULL), .EMPTY(EMPTY), .AFULL(AFULL),
    .AEMPTY(AEMPTY), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW), .WRCNT(WRCNT), .RDCNT(RDCNT));

  pdma_wconv_fifo #(.LSB_FIRST(1'b0)) u1 (
    .CLK(CLK), .RESET(RESET), .WE(WE), .DATA(DATA), .RE(RE), .FLUSH(FLUSH),
    .Q(q1), .DVLD(dvld1), .WACK(wack1), .FULL(full1), .EMPTY(empty1), .AFULL(afull1),
    .AEMPTY(aempty1), .OVERFLOW(ovf1), .UNDERFLOW(udf1), .WRCNT(wrcnt1), .RDCNT(rdcnt1));

  always #5 CLK = ~CLK;

  // Reference model: the FIFO seen as a queue of bytes in read order.
  logic [7:0] mq[$];
  logic [7:0] exp_q;
  bit         exp_dvld, exp_wack, exp_ovf, exp_udf;
  int         exp_wrcnt, exp_rdcnt;

  task automatic model_reset();
    mq.delete();
    exp_q = 8'h00; exp_dvld = 0; exp_wack = 0; exp_ovf = 0; exp_udf = 0;
    exp_wrcnt = 0; exp_rdcnt = 0;
  endtask

  task automatic cycle(input bit we, input bit re, input bit fl, input logic [15:0] d);
    bit full, empty;
    full  = ((mq.size() + 1) / 2 == WDEPTH);
    empty = (mq.size() == 0);
    exp_wack = 0; exp_dvld = 0; exp_ovf = 0; exp_udf = 0;
    if (fl) mq.delete();
    else begin
      if (re && !empty) begin exp_q = mq.pop_front(); exp_dvld = 1; end
      exp_udf = re && empty;
      exp_ovf = we && full;
      if (we && !full) begin mq.push_back(d[7:0]); mq.push_back(d[15:8]); exp_wack = 1; end
    end
    exp_rdcnt = mq.size();
    exp_wrcnt = (exp_rdcnt + 1) / 2;
    WE = we; RE = re; FLUSH = fl; DATA = d;
    @(posedge CLK); #1;
    WE = 0; RE = 0; FLUSH = 0;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    tests++; if (Q !== 8'h00) begin fails++; $display("FAIL reset_q got=%h exp=00", Q); end
    tests++; if ({DVLD, WACK, OVERFLOW, UNDERFLOW, FULL, AFULL} !== 6'b0) begin fails++; $display("FAIL reset_pulses got=%b exp=000000", {DVLD, WACK, OVERFLOW, UNDERFLOW, FULL, AFULL}); end
    tests++; if ({EMPTY, AEMPTY} !== 2'b11) begin fails++; $display("FAIL reset_empty got=%b exp=11", {EMPTY, AEMPTY}); end
    tests++; if (WRCNT !== 7'd0 || RDCNT !== 8'd0) begin fails++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", WRCNT, RDCNT); end
    tests++; if ({q1, dvld1, wack1, ovf1, udf1, full1, afull1, empty1, aempty1, wrcnt1, rdcnt1} !== {8'h00, 6'b0, 2'b11, 7'd0, 8'd0})
      begin fails++; $display("FAIL reset_u1 got=%h", {q1, dvld1, wack1, ovf1, udf1, full1, afull1, empty1, aempty1, wrcnt1, rdcnt1}); end
    #2 RESET = 1'b1;
  endtask

  task automatic test_order();
    cycle(1, 0, 0, 16'hA1B2);
    tests++; if (WACK !== 1'b1 || WRCNT !== 7'd1 || RDCNT !== 8'd2 || EMPTY !== 1'b0) begin fails++; $display("FAIL order_write got=%b/%0d/%0d/%b exp=1/1/2/0", WACK, WRCNT, RDCNT, EMPTY); end
    cycle(0, 1, 0, 16'h0);
    tests++; if (DVLD !== 1'b1 || Q !== 8'hB2) begin fails++; $display("FAIL order_lsb_first0 got=%b/%h exp=1/b2", DVLD, Q); end
    tests++; if (dvld1 !== 1'b1 || q1 !== 8'hA1) begin fails++; $display("FAIL order_msb_first0 got=%b/%h exp=1/a1", dvld1, q1); end
    tests++; if (WRCNT !== 7'd1 || RDCNT !== 8'd1) begin fails++; $display("FAIL order_mid_counts got=%0d/%0d exp=1/1", WRCNT, RDCNT); end
    cycle(0, 1, 0, 16'h0);
    tests++; if (DVLD !== 1'b1 || Q !== 8'hA1) begin fails++; $display("FAIL order_lsb_first1 got=%b/%h exp=1/a1", DVLD, Q); end
    tests++; if (dvld1 !== 1'b1 || q1 !== 8'hB2) begin fails++; $display("FAIL order_msb_first1 got=%b/%h exp=1/b2", dvld1, q1); end
    tests++; if (WRCNT !== 7'd0 || RDCNT !== 8'd0 || EMPTY !== 1'b1) begin fails++; $display("FAIL order_final got=%0d/%0d/%b exp=0/0/1", WRCNT, RDCNT, EMPTY); end
  endtask

  task automatic test_fill();
    int n;
    for (int i = 1; i <= 100; i++) begin
      cycle(1, 0, 0, 16'($urandom));
      tests++; if (AFULL !== (i >= AFVAL) || WACK !== 1'b1 || WRCNT !== 7'(i)) begin fails++; $display("FAIL fill_w%0d got=afull%b wack%b wrcnt%0d exp=afull%b wack1 wrcnt%0d", i, AFULL, WACK, WRCNT, i >= AFVAL, i); end
    end
    tests++; if (FULL !== 1'b1 || WRCNT !== 7'd100 || RDCNT !== 8'd200) begin fails++; $display("FAIL fill_full got=%b/%0d/%0d exp=1/100/200", FULL, WRCNT, RDCNT); end
    cycle(1, 0, 0, 16'hDEAD);
    tests++; if (OVERFLOW !== 1'b1 || WACK !== 1'b0 || WRCNT !== 7'd100 || RDCNT !== 8'd200) begin fails++; $display("FAIL fill_overflow got=%b/%b/%0d/%0d exp=1/0/100/200", OVERFLOW, WACK, WRCNT, RDCNT); end
    cycle(0, 1, 0, 16'h0);
    tests++; if (WRCNT !== 7'd100 || RDCNT !== 8'd199 || FULL !== 1'b1 || Q !== exp_q) begin fails++; $display("FAIL fill_read1 got=%0d/%0d/%b/%h exp=100/199/1/%h", WRCNT, RDCNT, FULL, Q, exp_q); end
    cycle(0, 1, 0, 16'h0);
    tests++; if (WRCNT !== 7'd99 || FULL !== 1'b0 || Q !== exp_q) begin fails++; $display("FAIL fill_read2 got=%0d/%b/%h exp=99/0/%h", WRCNT, FULL, Q, exp_q); end
    n = 0;
    while (mq.size() > 0 && n < 400) begin
      n++;
      cycle(0, 1, 0, 16'h0);
      tests++; if (DVLD !== 1'b1 || Q !== exp_q) begin fails++; $display("FAIL fill_drain got=%b/%h exp=1/%h", DVLD, Q, exp_q); end
    end
    tests++; if (EMPTY !== 1'b1 || RDCNT !== 8'd0) begin fails++; $display("FAIL fill_drained got=%b/%0d exp=1/0", EMPTY, RDCNT); end
  endtask

  task automatic test_underflow();
    cycle(0, 1, 0, 16'h0);
    tests++; if (UNDERFLOW !== 1'b1 || DVLD !== 1'b0 || Q !== exp_q) begin fails++; $display("FAIL udf_read got=%b/%b/%h exp=1/0/%h", UNDERFLOW, DVLD, Q, exp_q); end
    cycle(1, 1, 0, 16'h3C4D);
    tests++; if (WACK !== 1'b1 || UNDERFLOW !== 1'b1 || DVLD !== 1'b0 || RDCNT !== 8'd2) begin fails++; $display("FAIL udf_wr_rd got=%b/%b/%b/%0d exp=1/1/0/2", WACK, UNDERFLOW, DVLD, RDCNT); end
    cycle(0, 1, 0, 16'h0);
    tests++; if (Q !== 8'h4D || UNDERFLOW !== 1'b0) begin fails++; $display("FAIL udf_drain0 got=%h/%b exp=4d/0", Q, UNDERFLOW); end
    cycle(0, 1, 0, 16'h0);
    tests++; if (Q !== 8'h3C || EMPTY !== 1'b1) begin fails++; $display("FAIL udf_drain1 got=%h/%b exp=3c/1", Q, EMPTY); end
  endtask

  task automatic test_stream();
    int k, n, rb;
    bit we, re;
    logic [15:0] w;
    logic [7:0]  eb;
    k = 0; n = 0; rb = 0;
    while ((k < 250 || mq.size() > 0) && n < 5000) begin
      n++;
      we = (k < 250) && (exp_wrcnt < WDEPTH) && ($urandom_range(3) != 0);
      if (mq.size() > 2) re = ($urandom_range(1) == 1);
      else re = (k >= 250) && (mq.size() > 0);
      cycle(we, re, 0, 16'(k));
      if (exp_wack) k++;
      tests++; if (DVLD !== exp_dvld) begin fails++; $display("FAIL stream_dvld got=%b exp=%b", DVLD, exp_dvld); end
      if (exp_dvld) begin
        w  = 16'(rb / 2);
        eb = rb[0] ? w[15:8] : w[7:0];
        rb++;
        tests++; if (Q !== eb) begin fails++; $display("FAIL stream_byte%0d got=%h exp=%h", rb - 1, Q, eb); end
      end
      tests++; if (WRCNT !== 7'(exp_wrcnt) || RDCNT !== 8'(exp_rdcnt)) begin fails++; $display("FAIL stream_counts got=%0d/%0d exp=%0d/%0d", WRCNT, RDCNT, exp_wrcnt, exp_rdcnt); end
      tests++; if (!(int'(RDCNT) == 2 * int'(WRCNT) || int'(RDCNT) == 2 * int'(WRCNT) - 1)) begin fails++; $display("FAIL stream_invariant got=%0d/%0d exp=rdcnt=2*wrcnt-sidx", RDCNT, WRCNT); end
      tests++; if (AEMPTY !== (exp_rdcnt <= AEVAL)) begin fails++; $display("FAIL stream_aempty got=%b exp=%b", AEMPTY, exp_rdcnt <= AEVAL); end
    end
    tests++; if (n >= 5000 || rb != 500) begin fails++; $display("FAIL stream_complete got=%0d bytes exp=500", rb); end
  endtask

  task automatic test_flush();
    logic [15:0] w [10];
    for (int i = 0; i < 10; i++) begin
      w[i] = 16'($urandom);
      cycle(1, 0, 0, w[i]);
    end
    repeat (3) cycle(0, 1, 0, 16'h0);
    cycle(1, 1, 1, 16'hFFFF);
    tests++; if (WRCNT !== 7'd0 || RDCNT !== 8'd0 || EMPTY !== 1'b1 || AEMPTY !== 1'b1 || FULL !== 1'b0) begin fails++; $display("FAIL flush_counts got=%0d/%0d/%b/%b/%b exp=0/0/1/1/0", WRCNT, RDCNT, EMPTY, AEMPTY, FULL); end
    tests++; if (WACK !== 1'b0 || DVLD !== 1'b0 || OVERFLOW !== 1'b0 || UNDERFLOW !== 1'b0) begin fails++; $display("FAIL flush_pulses got=%b%b%b%b exp=0000", WACK, DVLD, OVERFLOW, UNDERFLOW); end
    tests++; if (Q !== w[1][7:0]) begin fails++; $display("FAIL flush_qhold got=%h exp=%h", Q, w[1][7:0]); end
    cycle(1, 0, 0, 16'h7788);
    cycle(0, 1, 0, 16'h0);
    tests++; if (Q !== 8'h88 || RDCNT !== 8'd1) begin fails++; $display("FAIL flush_resume got=%h/%0d exp=88/1", Q, RDCNT); end
    cycle(0, 1, 0, 16'h0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 50; i++) cycle(1, 0, 0, 16'($urandom) | 16'h0101);
    cycle(0, 1, 0, 16'h0);
    #3 RESET = 1'b0;
    #1;
    tests++; if (Q !== 8'h00 || q1 !== 8'h00 || WRCNT !== 7'd0 || RDCNT !== 8'd0) begin fails++; $display("FAIL areset_vals got=%h/%h/%0d/%0d exp=00/00/0/0", Q, q1, WRCNT, RDCNT); end
    tests++; if ({EMPTY, AEMPTY, FULL, AFULL, DVLD, WACK} !== 6'b110000) begin fails++; $display("FAIL areset_flags got=%b exp=110000", {EMPTY, AEMPTY, FULL, AFULL, DVLD, WACK}); end
    #2 RESET = 1'b1;
    model_reset();
    cycle(1, 0, 0, 16'h1234);
    tests++; if (WACK !== 1'b1 || RDCNT !== 8'd2) begin fails++; $display("FAIL areset_resume_w got=%b/%0d exp=1/2", WACK, RDCNT); end
    cycle(0, 1, 0, 16'h0);
    tests++; if (Q !== 8'h34) begin fails++; $display("FAIL areset_resume_r0 got=%h exp=34", Q); end
    cycle(0, 1, 0, 16'h0);
    tests++; if (Q !== 8'h12 || EMPTY !== 1'b1) begin fails++; $display("FAIL areset_resume_r1 got=%h/%b exp=12/1", Q, EMPTY); end
  endtask

  initial begin
    test_reset();
    test_order();
    test_fill();
    test_underflow();
    test_stream();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog");
  end

endmodule
